sobel_window_ctrl: RTL and testbench



---
 rtl/sobel_window_ctrl.sv | 206 ++++++++++++++++++++
 tb/tb_sobel_window_ctrl.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/sobel_window_ctrl.sv
// Sobel window sequencing controller: tracks frame/line/pixel position from the camera
// stream and flags the cycles where the 3x3 window holds a complete in-image neighbourhood.
module sobel_window_ctrl #(
    parameter int IMG_WIDTH  = 640,
    parameter int IMG_HEIGHT = 480,
    parameter int CW         = 10,
    parameter int RW         = 9
) (
    input  logic          sclk,
    input  logic          s_rst_n,
    input  logic          enable,
    input  logic          vsync,
    input  logic          original_href,
    input  logic          original_wrreq,
    output logic          win_valid,
    output logic [CW-1:0] win_col,
    output logic [RW-1:0] win_row,
    output logic          busy,
    output logic          frame_done,
    output logic          frame_err,
    output logic          line_err
);
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_FILL = 2'd1;
    localparam logic [1:0] ST_RUN  = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    localparam logic [CW-1:0] COL_ZERO = {CW{1'b0}};
    localparam logic [CW-1:0] COL_ONE  = CW'(1);
    localparam logic [CW-1:0] COL_TWO  = CW'(2);
    localparam logic [CW-1:0] COL_MAX  = {CW{1'b1}};
    localparam logic [CW-1:0] COL_W    = CW'(IMG_WIDTH);
    localparam logic [RW-1:0] ROW_ZERO = {RW{1'b0}};
    localparam logic [RW-1:0] ROW_ONE  = RW'(1);
    localparam logic [RW-1:0] ROW_FILL = RW'(2);
    localparam logic [RW-1:0] ROW_H    = RW'(IMG_HEIGHT);

    logic          href_r;
    logic          vsync_r;
    logic [1:0]    state_r;
    logic [1:0]    state_nxt_s;
    logic [CW-1:0] col_cnt_r;
    logic [RW-1:0] row_cnt_r;
    logic [RW-1:0] row_inc_s;

    logic          accept_s;
    logic          line_end_s;
    logic          vs_fall_s;
    logic          vs_rise_s;
    logic          active_s;
    logic          frame_start_s;
    logic          abort_s;
    logic          row_step_s;

    logic          raw_valid_s;
    logic [CW-1:0] raw_col_s;
    logic [RW-1:0] raw_row_s;

    logic          vld_p1_r;
    logic [CW-1:0] col_p1_r;
    logic [RW-1:0] row_p1_r;
    logic          vld_p2_r;
    logic [CW-1:0] col_p2_r;
    logic [RW-1:0] row_p2_r;

    logic          busy_r;
    logic          frame_done_r;
    logic          frame_err_r;
    logic          line_err_r;

    assign accept_s      = original_href & original_wrreq;
    assign line_end_s    = href_r & ~original_href;
    assign vs_fall_s     = vsync_r & ~vsync;
    assign vs_rise_s     = ~vsync_r & vsync;
    assign active_s      = (state_r == ST_FILL) || (state_r == ST_RUN);
    assign frame_start_s = (state_r == ST_IDLE) && vs_fall_s && enable;
    assign abort_s       = active_s && vs_rise_s;
    // An href glitch with no pixels is not a line.
    assign row_step_s    = line_end_s && (col_cnt_r != COL_ZERO);
    assign row_inc_s     = row_cnt_r + ROW_ONE;

    // col_cnt is the 0-based index of the incoming pixel, so the window centre lags by one.
    assign raw_valid_s = accept_s && (state_r == ST_RUN) && (col_cnt_r >= COL_TWO);
    assign raw_col_s   = col_cnt_r - COL_ONE;
    assign raw_row_s   = row_cnt_r - ROW_ONE;

    // Next-state decode for the frame sequencer.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (frame_start_s) begin
                    state_nxt_s = ST_FILL;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_FILL: begin
                if (vs_rise_s) begin
                    state_nxt_s = ST_IDLE;
                end else if (row_step_s && (row_inc_s == ROW_FILL)) begin
                    state_nxt_s = ST_RUN;
                end else begin
                    state_nxt_s = ST_FILL;
                end
            end
            ST_RUN: begin
                if (vs_rise_s) begin
                    state_nxt_s = ST_IDLE;
                end else if (row_step_s && (row_inc_s == ROW_H)) begin
                    state_nxt_s = ST_DONE;
                end else begin
                    state_nxt_s = ST_RUN;
                end
            end
            ST_DONE: begin
                state_nxt_s = ST_IDLE;
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // Edge-detect registers and state register.
    always_ff @(posedge sclk or negedge s_rst_n) begin
        if (!s_rst_n) begin
            href_r  <= 1'b0;
            vsync_r <= 1'b0;
            state_r <= ST_IDLE;
        end else begin
            href_r  <= original_href;
            vsync_r <= vsync;
            state_r <= state_nxt_s;
        end
    end

    // Column/row position counters; frame start and abort take priority over line events.
    always_ff @(posedge sclk or negedge s_rst_n) begin
        if (!s_rst_n) begin
            col_cnt_r <= COL_ZERO;
            row_cnt_r <= ROW_ZERO;
        end else if (frame_start_s || abort_s) begin
            col_cnt_r <= COL_ZERO;
            row_cnt_r <= ROW_ZERO;
        end else if (line_end_s) begin
            col_cnt_r <= COL_ZERO;
            if (row_step_s) begin
                row_cnt_r <= row_inc_s;
            end else begin
                row_cnt_r <= row_cnt_r;
            end
        end else if (accept_s && (col_cnt_r != COL_MAX)) begin
            col_cnt_r <= col_cnt_r + COL_ONE;
        end else begin
            col_cnt_r <= col_cnt_r;
        end
    end

    // Two-stage window pipe matching the generator's process_wrreq delay; coordinates hold between pulses.
    always_ff @(posedge sclk or negedge s_rst_n) begin
        if (!s_rst_n) begin
            vld_p1_r <= 1'b0;
            col_p1_r <= COL_ZERO;
            row_p1_r <= ROW_ZERO;
            vld_p2_r <= 1'b0;
            col_p2_r <= COL_ZERO;
            row_p2_r <= ROW_ZERO;
        end else begin
            vld_p1_r <= raw_valid_s;
            vld_p2_r <= vld_p1_r;
            if (raw_valid_s) begin
                col_p1_r <= raw_col_s;
                row_p1_r <= raw_row_s;
            end
            if (vld_p1_r) begin
                col_p2_r <= col_p1_r;
                row_p2_r <= row_p1_r;
            end
        end
    end

    // Registered status outputs and one-cycle event pulses.
    always_ff @(posedge sclk or negedge s_rst_n) begin
        if (!s_rst_n) begin
            busy_r       <= 1'b0;
            frame_done_r <= 1'b0;
            frame_err_r  <= 1'b0;
            line_err_r   <= 1'b0;
        end else begin
            busy_r       <= (state_nxt_s == ST_FILL) || (state_nxt_s == ST_RUN);
            frame_done_r <= (state_nxt_s == ST_DONE);
            frame_err_r  <= abort_s;
            line_err_r   <= row_step_s && active_s && (col_cnt_r != COL_W);
        end
    end

    assign win_valid  = vld_p2_r;
    assign win_col    = col_p2_r;
    assign win_row    = row_p2_r;
    assign busy       = busy_r;
    assign frame_done = frame_done_r;
    assign frame_err  = frame_err_r;
    assign line_err   = line_err_r;

endmodule

// File: tb/tb_sobel_window_ctrl.sv
// Self-checking bench for sobel_window_ctrl: builds per-cycle stimulus tables and derives the
// expected per-cycle outputs from frame/line/pixel events, then replays and compares.
module tb_sobel_window_ctrl;
    localparam int W    = 8;
    localparam int H    = 4;
    localparam int CW   = 10;
    localparam int RW   = 9;
    localparam int MAXC = 600;
    localparam int ASZ  = MAXC + 8;

    logic          sclk = 1'b0;
    logic          s_rst_n = 1'b0;
    logic          enable = 1'b0;
    logic          vsync = 1'b0;
    logic          original_href = 1'b0;
    logic          original_wrreq = 1'b0;
    logic          win_valid;
    logic [CW-1:0] win_col;
    logic [RW-1:0] win_row;
    logic          busy;
    logic          frame_done;
    logic          frame_err;
    logic          line_err;

    sobel_window_ctrl #(.IMG_WIDTH(W), .IMG_HEIGHT(H), .CW(CW), .RW(RW)) dut (
        .sclk           (sclk),
        .s_rst_n        (s_rst_n),
        .enable         (enable),
        .vsync          (vsync),
        .original_href  (original_href),
        .original_wrreq (original_wrreq),
        .win_valid      (win_valid),
        .win_col        (win_col),
        .win_row        (win_row),
        .busy           (busy),
        .frame_done     (frame_done),
        .frame_err      (frame_err),
        .line_err       (line_err)
    );

    always #5 sclk = ~sclk;

    int errors = 0;
    int checks = 0;
    int cur_cyc = 0;
    int n_cyc;

    // stimulus table
    logic s_vs [ASZ];
    logic s_hr [ASZ];
    logic s_wr [ASZ];
    logic s_en [ASZ];
    // expected outputs per cycle
    logic e_val  [ASZ];
    logic e_done [ASZ];
    logic e_err  [ASZ];
    logic e_lerr [ASZ];
    logic e_busy [ASZ];
    int   e_col  [ASZ];
    int   e_row  [ASZ];

    bit frm_on;
    int frm_line;
    int b_start;
    int exp_last_col;
    int exp_last_row;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s cycle %0d: got %0d expected %0d", tag, cur_cyc, obs, exp);
        end
    endtask

    task automatic clear_scn();
        n_cyc  = 0;
        frm_on = 1'b0;
        frm_line = 0;
        b_start = 0;
        for (int i = 0; i < ASZ; i++) begin
            s_vs[i] = 1'b0; s_hr[i] = 1'b0; s_wr[i] = 1'b0; s_en[i] = 1'b0;
            e_val[i] = 1'b0; e_done[i] = 1'b0; e_err[i] = 1'b0; e_lerr[i] = 1'b0;
            e_busy[i] = 1'b0; e_col[i] = 0; e_row[i] = 0;
        end
    endtask

    task automatic push(input logic v, input logic h, input logic w, input logic e);
        if (n_cyc >= MAXC) begin
            $display("FAIL scenario_size: got %0d cycles, limit %0d", n_cyc, MAXC);
            $fatal(1, "scenario table overflow");
        end
        s_vs[n_cyc] = v; s_hr[n_cyc] = h; s_wr[n_cyc] = w; s_en[n_cyc] = e;
        n_cyc++;
    endtask

    // frame ends: busy was high from the cycle after frame start up to (not incl.) 'at'
    task automatic end_frame(input int at);
        for (int i = b_start; i < at; i++) e_busy[i] = 1'b1;
        frm_on = 1'b0;
    endtask

    task automatic add_blank(input int k, input logic en);
        for (int i = 0; i < k; i++) push(1'b0, 1'b0, 1'b0, en);
    endtask

    // remaining high vsync cycles, then the falling-edge cycle where enable is sampled
    task automatic vs_tail(input int k, input logic en);
        for (int i = 0; i < k; i++) push(1'b1, 1'b0, 1'b0, en);
        if (en) begin
            frm_on = 1'b1;
            frm_line = 0;
            b_start = n_cyc + 1;
        end
        push(1'b0, 1'b0, 1'b0, en);
    endtask

    task automatic add_vsync(input int k, input logic en);
        if (frm_on) begin
            e_err[n_cyc + 1] = 1'b1;
            end_frame(n_cyc + 1);
        end
        vs_tail(k, en);
    endtask

    // pixels of one line; gap mode 0 contiguous, 1 every other cycle, 2 random gaps
    task automatic add_pixels(input int len, input int mode, input logic en);
        int c;
        for (int k = 0; k < len; k++) begin
            if (mode == 1 && k > 0) push(1'b0, 1'b1, 1'b0, en);
            if (mode == 2) begin
                int g;
                g = $urandom_range(0, 2);
                for (int j = 0; j < g; j++) push(1'b0, 1'b1, 1'b0, en);
            end
            c = n_cyc;
            push(1'b0, 1'b1, 1'b1, en);
            if (frm_on && frm_line >= 2 && k >= 2) begin
                e_val[c + 2] = 1'b1;
                e_col[c + 2] = k - 1;
                e_row[c + 2] = frm_line - 1;
            end
        end
    endtask

    task automatic add_line(input int len, input int mode, input logic en);
        int e;
        if (len == 0) push(1'b0, 1'b1, 1'b0, en);
        add_pixels(len, mode, en);
        e = n_cyc;
        push(1'b0, 1'b0, 1'b0, en);
        if (frm_on && len > 0) begin
            if (len != W) e_lerr[e + 1] = 1'b1;
            frm_line++;
            if (frm_line == H) begin
                e_done[e + 1] = 1'b1;
                end_frame(e + 1);
            end
        end
        add_blank($urandom_range(1, 4), en);
    endtask

    // vsync rises while href is still high after npix pixels of the current line
    task automatic add_abort_line(input int npix, input logic en);
        add_pixels(npix, 0, en);
        if (frm_on) begin
            e_err[n_cyc + 1] = 1'b1;
            end_frame(n_cyc + 1);
        end
        push(1'b1, 1'b1, 1'b0, en);
        vs_tail(2, en);
    endtask

    task automatic add_frame(input int mode, input logic en_start, input logic en_body);
        add_vsync(3, en_start);
        for (int l = 0; l < H; l++) add_line(W, mode, en_body);
    endtask

    task automatic check_outputs(input int n);
        if (e_val[n]) begin
            exp_last_col = e_col[n];
            exp_last_row = e_row[n];
        end
        chk("win_valid", 32'(win_valid), 32'(e_val[n]));
        chk("win_col", 32'(win_col), exp_last_col);
        chk("win_row", 32'(win_row), exp_last_row);
        chk("frame_done", 32'(frame_done), 32'(e_done[n]));
        chk("frame_err", 32'(frame_err), 32'(e_err[n]));
        chk("line_err", 32'(line_err), 32'(e_lerr[n]));
        chk("busy", 32'(busy), 32'(e_busy[n]));
    endtask

    task automatic run_scn();
        if (frm_on) end_frame(n_cyc);
        for (int n = 0; n < n_cyc; n++) begin
            @(posedge sclk);
            #1;
            vsync          = s_vs[n];
            original_href  = s_hr[n];
            original_wrreq = s_wr[n];
            enable         = s_en[n];
            @(negedge sclk);
            cur_cyc = n;
            check_outputs(n);
        end
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_win_valid"}, 32'(win_valid), 32'd0);
        chk({tag, "_win_col"}, 32'(win_col), 32'd0);
        chk({tag, "_win_row"}, 32'(win_row), 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_frame_done"}, 32'(frame_done), 32'd0);
        chk({tag, "_frame_err"}, 32'(frame_err), 32'd0);
        chk({tag, "_line_err"}, 32'(line_err), 32'd0);
    endtask

    initial begin
        exp_last_col = 0;
        exp_last_row = 0;

        // reset state
        repeat (3) @(posedge sclk);
        @(negedge sclk);
        check_all_zero("reset");
        s_rst_n = 1'b1;

        // nominal frame, contiguous pixels
        clear_scn(); add_blank(2, 1'b1); add_frame(0, 1'b1, 1'b1); add_blank(6, 1'b1); run_scn();

        // every-other-cycle pixels; enable dropped right after frame start
        clear_scn(); add_blank(2, 1'b1); add_frame(1, 1'b1, 1'b0); add_blank(6, 1'b0); run_scn();

        // random gaps plus an href glitch with no pixels
        clear_scn(); add_blank(2, 1'b1); add_vsync(3, 1'b1);
        add_line(W, 2, 1'b1); add_line(0, 0, 1'b1); add_line(W, 2, 1'b1);
        add_line(W, 2, 1'b1); add_line(W, 2, 1'b1); add_blank(6, 1'b1); run_scn();

        // short line 2
        clear_scn(); add_blank(2, 1'b1); add_vsync(3, 1'b1);
        add_line(W, 2, 1'b1); add_line(W, 2, 1'b1); add_line(W - 1, 2, 1'b1);
        add_line(W, 2, 1'b1); add_blank(6, 1'b1); run_scn();

        // abort during line 2, then a clean frame from the same vsync pulse
        clear_scn(); add_blank(2, 1'b1); add_vsync(3, 1'b1);
        add_line(W, 0, 1'b1); add_line(W, 0, 1'b1); add_abort_line(4, 1'b1);
        for (int l = 0; l < H; l++) add_line(W, 2, 1'b1);
        add_blank(6, 1'b1); run_scn();

        // disabled at frame start
        clear_scn(); add_blank(2, 1'b0); add_frame(2, 1'b0, 1'b1); add_blank(6, 1'b0); run_scn();

        // reset mid-RUN
        clear_scn(); add_blank(2, 1'b1); add_vsync(3, 1'b1);
        add_line(W, 0, 1'b1); add_line(W, 0, 1'b1); add_pixels(5, 0, 1'b1); run_scn();
        @(posedge sclk);
        #3;
        s_rst_n = 1'b0;
        #1;
        check_all_zero("async_rst");
        vsync = 1'b0; original_href = 1'b0; original_wrreq = 1'b0; enable = 1'b0;
        exp_last_col = 0;
        exp_last_row = 0;
        repeat (2) @(posedge sclk);
        @(negedge sclk);
        s_rst_n = 1'b1;
        clear_scn(); add_blank(2, 1'b1); add_frame(0, 1'b1, 1'b1); add_blank(6, 1'b1); run_scn();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
